// File: rtl/wb_reg_intercon.sv
// wb_reg_intercon: registered Wishbone 1:N register interconnect.
// The upper SEL_BITS of the host address pick one of NUM_TARGETS downstream
// targets; one transaction at a time runs through IDLE -> TRANSACTION -> FINISH.
// Unmapped targets and target errors return wb_err_o; a host that drops cyc
// mid-transaction aborts it without a response.
// Optional feature macro: WB_INTERCON_TIMEOUT_EN (hang timeout forcing an error
// after TIMEOUT_CYCLES cycles in TRANSACTION).
module wb_reg_intercon #(
  parameter int NUM_TARGETS    = 4,
  parameter int SEL_BITS       = 2,
  parameter int DN_ADR_WIDTH   = 13,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic                                  wb_cyc_i,
  input  logic                                  wb_stb_i,
  input  logic                                  wb_we_i,
  input  logic [SEL_BITS+DN_ADR_WIDTH-1:0]      wb_adr_i,
  input  logic [DATA_WIDTH-1:0]                 wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0]               wb_sel_i,
  output logic [DATA_WIDTH-1:0]                 wb_dat_o,
  output logic                                  wb_ack_o,
  output logic                                  wb_err_o,
  output logic                                  wb_rty_o,
  output logic [NUM_TARGETS-1:0]                dn_cyc_o,
  output logic [NUM_TARGETS-1:0]                dn_stb_o,
  output logic [NUM_TARGETS-1:0]                dn_we_o,
  output logic [NUM_TARGETS*DN_ADR_WIDTH-1:0]   dn_adr_o,
  output logic [NUM_TARGETS*DATA_WIDTH-1:0]     dn_dat_o,
  output logic [NUM_TARGETS*DATA_WIDTH/8-1:0]   dn_sel_o,
  input  logic [NUM_TARGETS*DATA_WIDTH-1:0]     dn_dat_i,
  input  logic [NUM_TARGETS-1:0]                dn_ack_i,
  input  logic [NUM_TARGETS-1:0]                dn_err_i
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int AW = SEL_BITS + DN_ADR_WIDTH;

  // Catch impossible configurations at elaboration.
  if (NUM_TARGETS < 1 || NUM_TARGETS > 16 || (1 << SEL_BITS) < NUM_TARGETS ||
      (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wb_reg_intercon: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    TRANSACTION,
    FINISH
  } state_t;

  state_t                  state;
  logic                    cap_we;
  logic [SEL_BITS-1:0]     req_tgt;
  logic [NUM_TARGETS-1:0]  req_dec;
  logic                    rsp_ack;
  logic                    rsp_err;
  logic                    rsp_is_err;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    to_hit;

  assign wb_rty_o = 1'b0;
  assign req_tgt  = wb_adr_i[AW-1:DN_ADR_WIDTH];

  // Decode the requested target to one-hot; all-zero means unmapped.
  always_comb begin
    req_dec = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      req_dec[i] = (req_tgt == SEL_BITS'(i));
    end
  end

  // dn_cyc_o is one-hot on the active target in TRANSACTION and zero elsewhere,
  // so it doubles as the response/read-data select mask.
  always_comb begin
    rsp_ack = |(dn_ack_i & dn_cyc_o);
    rsp_err = |(dn_err_i & dn_cyc_o);
    rd_mux  = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (dn_cyc_o[i]) begin
        rd_mux = rd_mux | dn_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef WB_INTERCON_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // The count reaches TIMEOUT_CYCLES on the edge that abandons the target.
  assign to_hit = (state == TRANSACTION) && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Cycles spent in TRANSACTION; held at zero outside it.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
    end else if (state == TRANSACTION) begin
      to_cnt <= to_cnt + TW'(1);
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // A real response in the same cycle as the timeout takes precedence; err beats ack.
  assign rsp_is_err = rsp_err | (to_hit & ~rsp_ack);

  // Transaction FSM with all host and downstream outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      cap_we   <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      dn_cyc_o <= '0;
      dn_stb_o <= '0;
      dn_we_o  <= '0;
      dn_adr_o <= '0;
      dn_dat_o <= '0;
      dn_sel_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
          if (wb_cyc_i && wb_stb_i) begin
            cap_we <= wb_we_i;
            if (|req_dec) begin
              state    <= TRANSACTION;
              dn_cyc_o <= req_dec;
              dn_stb_o <= req_dec;
              dn_we_o  <= wb_we_i ? req_dec : '0;
              for (int i = 0; i < NUM_TARGETS; i++) begin
                dn_adr_o[i*DN_ADR_WIDTH +: DN_ADR_WIDTH] <=
                  req_dec[i] ? wb_adr_i[DN_ADR_WIDTH-1:0] : '0;
                dn_dat_o[i*DATA_WIDTH +: DATA_WIDTH] <= req_dec[i] ? wb_dat_i : '0;
                dn_sel_o[i*SW +: SW] <= req_dec[i] ? wb_sel_i : '0;
              end
            end else begin
              state    <= FINISH;
              wb_err_o <= 1'b1;
            end
          end
        end

        TRANSACTION: begin
          if (!wb_cyc_i || rsp_ack || rsp_err || to_hit) begin
            dn_cyc_o <= '0;
            dn_stb_o <= '0;
            dn_we_o  <= '0;
            dn_adr_o <= '0;
            dn_dat_o <= '0;
            dn_sel_o <= '0;
          end
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (rsp_ack || rsp_err || to_hit) begin
            state    <= FINISH;
            wb_err_o <= rsp_is_err;
            wb_ack_o <= ~rsp_is_err;
            wb_dat_o <= (!rsp_is_err && !cap_we) ? rd_mux : '0;
          end
        end

        FINISH: begin
          state    <= IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_reg_intercon.sv
// Directed bench for wb_reg_intercon with NUM_TARGETS=3 so that index 3 is unmapped.
// Build with WB_INTERCON_TIMEOUT_EN defined to exercise the hang timeout.
module tb_wb_reg_intercon;

  localparam int NT = 3;
  localparam int SB = 2;
  localparam int AW = 13;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc, stb, we;
  logic [SB+AW-1:0]  adr;
  logic [DW-1:0]     wdat;
  logic [DW/8-1:0]   sel;
  logic [DW-1:0]     rdat;
  logic              ack, err, rty;
  logic [NT-1:0]     d_cyc, d_stb, d_we;
  logic [NT*AW-1:0]  d_adr;
  logic [NT*DW-1:0]  d_dat_o;
  logic [NT*DW/8-1:0] d_sel;
  logic [NT*DW-1:0]  d_dat_i;
  logic [NT-1:0]     d_ack, d_err;

  int n_total = 0;
  int n_bad   = 0;

  wb_reg_intercon #(
    .NUM_TARGETS(NT), .SEL_BITS(SB), .DN_ADR_WIDTH(AW),
    .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_dat_o(rdat), .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty),
    .dn_cyc_o(d_cyc), .dn_stb_o(d_stb), .dn_we_o(d_we),
    .dn_adr_o(d_adr), .dn_dat_o(d_dat_o), .dn_sel_o(d_sel),
    .dn_dat_i(d_dat_i), .dn_ack_i(d_ack), .dn_err_i(d_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input logic w, input logic [SB+AW-1:0] a, input logic [DW-1:0] d);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = 4'hF;
  endtask

  task automatic host_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit_cyc;
    rst = 1'b1; host_idle();
    d_dat_i = '0; d_ack = '0; d_err = '0;
    tick(); tick();
    check_val("rst_ack", ack, 0);
    check_val("rst_err", err, 0);
    check_val("rst_dat", rdat, 0);
    check_val("rst_dcyc", d_cyc, 0);
    check_val("rst_dadr", d_adr, 0);
    check_val("rst_rty", rty, 0);
    rst = 1'b0;
    tick();

    // Write 0xDEADBEEF to target 2 at 0x0ABC; ack in the 4th cycle of cyc.
    host_req(1'b1, {2'b10, 13'h0ABC}, 32'hDEADBEEF);
    tick();
    check_val("wr_dcyc", d_cyc, 3'b100);
    check_val("wr_dstb", d_stb, 3'b100);
    check_val("wr_dwe", d_we, 3'b100);
    check_val("wr_dadr", d_adr, {13'h0ABC, 13'h0, 13'h0});
    check_val("wr_ddat", d_dat_o, {32'hDEADBEEF, 64'h0});
    check_val("wr_dsel", d_sel, {4'hF, 8'h0});
    tick(); tick(); tick();
    d_ack = 3'b100;
    check_val("wr_wait_ack", ack, 0);
    check_val("wr_wait_dcyc", d_cyc, 3'b100);
    tick();
    d_ack = '0;
    check_val("wr_ack", ack, 1);
    check_val("wr_err", err, 0);
    check_val("wr_dcyc_off", d_cyc, 0);
    check_val("wr_dat", rdat, 0);
    host_idle();
    tick();
    check_val("wr_ack_once", ack, 0);

    // Read target 1, combinational ack in cycle 1; slice 0 carries noise.
    host_req(1'b0, {2'b01, 13'h0010}, 32'h0);
    tick();
    check_val("rd_dcyc", d_cyc, 3'b010);
    check_val("rd_dwe", d_we, 3'b000);
    d_dat_i = {32'h0, 32'h12345678, 32'hFFFF0000};
    d_ack = 3'b010;
    tick();
    d_ack = '0;
    check_val("rd_ack", ack, 1);
    check_val("rd_dat", rdat, 32'h12345678);
    host_idle();
    tick();
    check_val("rd_ack_off", ack, 0);
    check_val("rd_dat_off", rdat, 0);

    // Unmapped index 3 with a stray ack from target 0.
    host_req(1'b0, {2'b11, 13'h0001}, 32'h0);
    d_ack = 3'b001;
    tick();
    d_ack = '0;
    check_val("um_err", err, 1);
    check_val("um_ack", ack, 0);
    check_val("um_dcyc", d_cyc, 0);
    host_idle();
    tick();
    check_val("um_err_off", err, 0);
    check_val("um_ack_off", ack, 0);

    // Responses from non-selected targets are ignored.
    host_req(1'b0, {2'b01, 13'h0002}, 32'h0);
    tick();
    d_ack = 3'b101; d_err = 3'b100;
    tick();
    check_val("ns_ack", ack, 0);
    check_val("ns_err", err, 0);
    check_val("ns_dcyc", d_cyc, 3'b010);
    d_ack = 3'b010; d_err = '0;
    tick();
    d_ack = '0;
    check_val("ns_final_ack", ack, 1);
    host_idle();
    tick();

    // Target 0 raises ack and err together: err wins, data 0.
    host_req(1'b0, {2'b00, 13'h0005}, 32'h0);
    tick();
    d_dat_i = {64'h0, 32'hCAFEF00D};
    d_ack = 3'b001; d_err = 3'b001;
    tick();
    d_ack = '0; d_err = '0;
    check_val("ae_err", err, 1);
    check_val("ae_ack", ack, 0);
    check_val("ae_dat", rdat, 0);
    host_idle();
    tick();

    // Reset during a write to target 2.
    host_req(1'b1, {2'b10, 13'h0003}, 32'h55AA55AA);
    tick();
    check_val("mr_dcyc_on", d_cyc, 3'b100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("mr_dcyc", d_cyc, 0);
    check_val("mr_ddat", d_dat_o, 0);
    check_val("mr_ack", ack, 0);
    check_val("mr_err", err, 0);
    host_idle();
    tick();
    check_val("mr_no_rsp", {ack, err}, 2'b00);

    // Host abort while target 0 is silent.
    host_req(1'b0, {2'b00, 13'h0007}, 32'h0);
    tick();
    check_val("ab_dcyc_on", d_cyc, 3'b001);
    host_idle();
    tick();
    check_val("ab_dcyc", d_cyc, 0);
    tick();
    check_val("ab_no_rsp", {ack, err}, 2'b00);

    // Silent target 1.
    host_req(1'b0, {2'b01, 13'h0009}, 32'h0);
    tick();
    check_val("to_dcyc_on", d_cyc, 3'b010);
    hit_cyc = 0;
`ifdef WB_INTERCON_TIMEOUT_EN
    for (int c = 2; c < 40 && hit_cyc == 0; c++) begin
      tick();
      if (err) hit_cyc = c;
    end
    check_val("to_err_cycle", hit_cyc, 17);
    check_val("to_ack", ack, 0);
    check_val("to_dat", rdat, 0);
    check_val("to_dcyc_off", d_cyc, 0);
    host_idle();
    d_dat_i = {32'h0, 32'h77777777, 32'h0};
    d_ack = 3'b010;
    tick();
    d_ack = '0;
    tick();
    check_val("to_late_ack", {ack, err}, 2'b00);
`else
    for (int c = 2; c < 32; c++) begin
      tick();
      if (err || ack) hit_cyc = c;
    end
    check_val("hang_no_rsp", hit_cyc, 0);
    check_val("hang_dcyc", d_cyc, 3'b010);
    host_idle();
    tick();
    check_val("hang_dcyc_off", d_cyc, 0);
    tick();
    check_val("hang_no_rsp_after", {ack, err}, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_reg_intercon.md
Name: wb_reg_intercon

Overview:
Parametrised, fully registered Wishbone 1:N interconnect, the successor to the fixed four-target L1 register interconnect. It decodes the upper host address bits to one of NUM_TARGETS downstream register targets and runs exactly one transaction at a time through a registered FSM, which keeps fanout and timing off the ACLK-side logic. Unlike the previous generation, it adds an error response for unmapped or erroring targets, host-abort handling, and an optional hang timeout.

Parameters:
NUM_TARGETS, 4, number of downstream targets (1..16)
SEL_BITS, 2, host address bits used for target decode; 2**SEL_BITS >= NUM_TARGETS
DN_ADR_WIDTH, 13, downstream address width
DATA_WIDTH, 32, data width; multiple of 8
TIMEOUT_CYCLES, 1024, cycles in TRANSACTION before forced error (only with the optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  host request
wb_adr_i  in  SEL_BITS+DN_ADR_WIDTH  host address; [top SEL_BITS] select the target
wb_dat_i  in  DATA_WIDTH  write data
wb_sel_i  in  DATA_WIDTH/8  byte enables
wb_dat_o  out  DATA_WIDTH  read data
wb_ack_o, wb_err_o  out  1 each  one-cycle response
wb_rty_o  out  1  tied 0
dn_cyc_o, dn_stb_o, dn_we_o  out  NUM_TARGETS  per-target request
dn_adr_o  out  NUM_TARGETS*DN_ADR_WIDTH  per-target address, flattened
dn_dat_o  out  NUM_TARGETS*DATA_WIDTH  per-target write data
dn_sel_o  out  NUM_TARGETS*DATA_WIDTH/8  per-target byte enables
dn_dat_i  in  NUM_TARGETS*DATA_WIDTH  per-target read data
dn_ack_i, dn_err_i  in  NUM_TARGETS  per-target response

Behaviour:
- Reset is synchronous and active-high. After reset: state IDLE; every output is 0, including all dn_* outputs, wb_ack_o, wb_err_o and wb_dat_o.
- FSM states: IDLE, TRANSACTION, FINISH.
- IDLE:
  - On wb_cyc_i & wb_stb_i, capture the target index t, address low bits, we, data and sel.
  - If t < NUM_TARGETS, go to TRANSACTION. Otherwise go to FINISH with err flagged and no downstream access.
- TRANSACTION:
  - dn_cyc_o[t] = dn_stb_o[t] = 1.
  - dn_adr/dat/sel/we slice t carries the captured values. All unselected slices are held at 0.
  - dn_stb_o equals dn_cyc_o.
- Response sampling:
  - When dn_ack_i[t] or dn_err_i[t] is sampled: clear dn_cyc_o[t] on that edge and go to FINISH.
  - On a read ack, latch dn_dat_i slice t. On a write or an error, latch 0.
  - If ack and err arrive together, err wins.
- FINISH: exactly one cycle with wb_ack_o or wb_err_o high (mutually exclusive), with wb_dat_o valid, then return to IDLE. wb_dat_o returns to 0 in IDLE.
- Latency: request sampled at edge 0 → dn_cyc_o high in cycle 1. With a target responding combinationally in cycle 1, the host response appears in cycle 2. An unmapped target responds in cycle 1.
- Acks and errs from non-selected targets, or arriving while in IDLE or FINISH, are ignored.
- Host abort: if wb_cyc_i drops in TRANSACTION, drop dn_cyc_o next edge and return to IDLE with no host response.
- The host must deassert stb after a response. A request still present in IDLE is treated as a new transaction.
- Reset mid-transaction: the next edge clears all dn_cyc_o and returns to IDLE with no response.

Optional Feature:
Macro WB_INTERCON_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on IDLE→TRANSACTION and increments each TRANSACTION cycle.
  - When it reaches TIMEOUT_CYCLES: drop dn_cyc_o[t], go to FINISH, assert wb_err_o with data 0.
  - A later ack from that target is ignored.
- Undefined: no counter exists, and a non-responding target hangs the bus until host abort or reset.

Test Plan:
- Write 0xDEADBEEF to target 2 (adr top bits 2'b10, low 0x0ABC), target acks 3 cycles after cyc → dn_adr slice2=0x0ABC, dn_dat slice2=0xDEADBEEF, other slices 0; one-cycle wb_ack_o, wb_err_o=0.
- Read target 1, target returns 0x12345678 with ack in cycle 1 → wb_ack_o in cycle 2, wb_dat_o=0x12345678 for one cycle, then 0.
- NUM_TARGETS=3, access index 3 → no dn_cyc_o; wb_err_o in cycle 1; dn_ack_i[0] pulsed meanwhile has no effect.
- Target 0 asserts ack and err simultaneously → wb_err_o=1, wb_ack_o=0. Assert wb_rst_i during a later transaction → all outputs 0 next cycle, no response.
- With WB_INTERCON_TIMEOUT_EN and TIMEOUT_CYCLES=16, silent target → wb_err_o exactly 16 cycles after dn_cyc_o rises; late ack ignored. Without the macro, the same target holds dn_cyc_o until wb_cyc_i drops.
